nn_argmax_classifier: RTL and testbench
=======================================

// Module: nn_argmax_classifier
// PURPOSE
//  Final classification stage, directly downstream of the output layer (nn_layer_3).
//  Captures the NUM_NEURONS parallel neuron outputs when the layer's all-neurons-valid flag rises.
//  Scans them serially, one compare per cycle, and reports the index and value of the largest output.
//  The index is the predicted class, e.g. digit 0-9 for the 784-input / 10-output network.
// PARAMETERS
//  NUM_NEURONS  10  number of layer outputs (classes); legal range >= 2
//  data_width   16  width of each neuron output; signed two's complement fixed point
//  IDX_W        $clog2(NUM_NEURONS)  width of class index (derived localparam, not overridable)
// PORTS
//  clk        in   1                         clock, all logic on rising edge
//  rst        in   1                         synchronous, active-high reset
//  in         in   [NUM_NEURONS-1:0][data_width-1:0]  layer outputs; element i = neuron i
//  valid_in   in   1                         layer valid_out; level signal, may stay high
//  class_out  out  IDX_W                     index of the maximum element
//  max_out    out  data_width                value of the maximum element
//  valid_out  out  1                         one-cycle pulse: class_out/max_out updated this cycle
//  busy       out  1                         high while a capture or scan is in progress
// BEHAVIOUR
//  Reset (rst=1 at an edge), from any state, including mid-scan:
//   - state=IDLE; class_out=0, max_out=0, valid_out=0, busy=0.
//   - capture regs and counter are cleared; valid_in_d=0.
//   - If valid_in is high when rst drops, that counts as a rising edge.
//  Start condition: start = valid_in & ~valid_in_d, with valid_in_d registered every cycle.
//   - Only a rising edge starts a job. A level held high does not retrigger.
//  FSM:
//   - IDLE: on start at edge k, latch all of `in` into cap[], best_val=cap[0], best_idx=0, cnt=1.
//     Go to SCAN; busy=1 from edge k.
//   - SCAN: each edge, if $signed(cap[cnt]) > $signed(best_val), then best_val=cap[cnt] and best_idx=cnt.
//     Then cnt++. Compare cap[NUM_NEURONS-1] happens at edge k+NUM_NEURONS-1 -> DONE.
//   - DONE: at edge k+NUM_NEURONS, class_out=best_idx, max_out=best_val, valid_out=1, busy=0 -> IDLE.
//   - valid_out falls at the next edge.
//  Latency: valid_out is high in the cycle after edge k+NUM_NEURONS, i.e. NUM_NEURONS cycles after the capture edge.
//  class_out and max_out hold their last result until the next DONE or reset.
//  Ties: strict greater-than, so the lowest index among equal maxima wins.
//  Arithmetic: signed compare only, no rounding or saturation. max_out is a bit-exact copy of the winning input.
//  Start while busy (SCAN/DONE): ignored, with no queuing. valid_in_d still tracks, so an edge during busy is lost.
//  Inputs are sampled only at the capture edge. Changes on `in` during SCAN have no effect.
//  Capture may occur in the same cycle the DONE/IDLE transition completes only if state==IDLE at that edge.
//  Back-to-back jobs therefore have a minimum spacing of NUM_NEURONS+1 cycles.
// TESTING (NUM_NEURONS=10, data_width=16)
//  1. Basic: in[i]=i*16'h0100, with in[7]=16'h7000; valid_in 0->1 at edge k.
//     -> busy 1 for edges k..k+9; valid_out=1 for one cycle after edge k+10; class_out=7, max_out=16'h7000.
//  2. Signed/negatives: all in = 16'h8000 except in[3]=16'hFFFF (-1).
//     -> class_out=3, max_out=16'hFFFF. Also all-equal 16'h1234 -> class_out=0, ties resolve low.
//  3. Hold/retrigger: valid_in held high 40 cycles with fixed data.
//     -> exactly one valid_out pulse. Drop valid_in 1 cycle and raise it again after DONE -> second pulse, same result.
//  4. Busy ignore: second rising edge of valid_in 3 cycles after start, with different data (max at index 9).
//     -> only the first job's result appears; no second valid_out.
//  5. Reset mid-scan: assert rst at edge k+4.
//     -> next cycle class_out=0, max_out=0, valid_out=0, busy=0, and no pulse follows.
//     With valid_in high when rst drops -> a new job starts and completes 10 cycles later.
//  6. Boundary index: maximum only at in[9], then only at in[0].
//     -> class_out=9, then class_out=0. Also run NUM_NEURONS=2: latency 2 cycles.

Source files
------------

// File: rtl/nn_argmax_classifier.sv
// Argmax stage behind the output layer: captures all neuron outputs on a
// rising valid edge, scans them one per cycle, reports winning index and value.
module nn_argmax_classifier #(
    parameter int NUM_NEURONS = 10,
    parameter int data_width  = 16,
    localparam int IDX_W      = $clog2(NUM_NEURONS)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_NEURONS-1:0][data_width-1:0]  in,
    input  logic                                    valid_in,
    output logic [IDX_W-1:0]                        class_out,
    output logic [data_width-1:0]                   max_out,
    output logic                                    valid_out,
    output logic                                    busy
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_n;

    logic                                   valid_in_d;
    logic                                   start;
    logic [NUM_NEURONS-1:0][data_width-1:0] cap;
    logic [data_width-1:0]                  best_val;
    logic [IDX_W-1:0]                       best_idx;
    logic [IDX_W-1:0]                       cnt;
    logic [data_width-1:0]                  cur;
    logic                                   better;

    // A level held high must not retrigger, so only the rising edge starts a job.
    assign start = valid_in & ~valid_in_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (start) state_n = SCAN;
            SCAN: if (cnt == LAST) state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_comb begin
        cur    = cap[cnt];
        better = ($signed(cur) > $signed(best_val));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_in_d <= 1'b0;
            cap        <= '0;
            best_val   <= '0;
            best_idx   <= '0;
            cnt        <= '0;
            class_out  <= '0;
            max_out    <= '0;
            valid_out  <= 1'b0;
        end else begin
            valid_in_d <= valid_in;
            valid_out  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cap      <= in;
                        best_val <= in[0];
                        best_idx <= '0;
                        cnt      <= IDX_W'(1);
                    end
                end
                SCAN: begin
                    // Strict compare keeps the lowest index among equal maxima.
                    if (better) begin
                        best_val <= cur;
                        best_idx <= cnt;
                    end
                    if (cnt != LAST) begin
                        cnt <= cnt + IDX_W'(1);
                    end
                end
                DONE: begin
                    class_out <= best_idx;
                    max_out   <= best_val;
                    valid_out <= 1'b1;
                    cnt       <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_argmax_classifier.sv
// Scoreboard bench for nn_argmax_classifier (10x16 instance plus a 2-class instance).
module tb_nn_argmax_classifier;

    localparam int N  = 10;
    localparam int DW = 16;

    typedef logic [N-1:0][DW-1:0] vec_t;
    typedef struct {
        logic [3:0]    idx;
        logic [DW-1:0] val;
        int            cyc;
    } sb_t;

    logic          clk = 1'b0;
    logic          rst;
    vec_t          in;
    logic          valid_in;
    logic [3:0]    class_out;
    logic [DW-1:0] max_out;
    logic          valid_out;
    logic          busy;

    logic [1:0][DW-1:0] in2;
    logic               valid_in2;
    logic [0:0]         class2;
    logic [DW-1:0]      max2;
    logic               valid2;
    logic               busy2;

    int  n_chk  = 0;
    int  n_pass = 0;
    int  cyc    = 0;
    sb_t sb[$];

    nn_argmax_classifier #(.NUM_NEURONS(N), .data_width(DW)) dut (
        .clk(clk), .rst(rst), .in(in), .valid_in(valid_in),
        .class_out(class_out), .max_out(max_out),
        .valid_out(valid_out), .busy(busy)
    );

    nn_argmax_classifier #(.NUM_NEURONS(2), .data_width(DW)) dut2 (
        .clk(clk), .rst(rst), .in(in2), .valid_in(valid_in2),
        .class_out(class2), .max_out(max2),
        .valid_out(valid2), .busy(busy2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic sb_t ref_model(input vec_t v, input int c);
        sb_t e;
        e.idx = 0;
        e.val = v[0];
        for (int i = 1; i < N; i++) begin
            if ($signed(v[i]) > $signed(e.val)) begin
                e.val = v[i];
                e.idx = 4'(i);
            end
        end
        e.cyc = c;
        return e;
    endfunction

    always @(posedge clk) begin
        #1;
        if (valid_out) begin
            if (sb.size() == 0) begin
                chk("spurious_pulse", 32'(valid_out), 32'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("class", 32'(class_out), 32'(e.idx));
                chk("max", 32'(max_out), 32'(e.val));
                chk("latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic start_job(input vec_t v);
        @(negedge clk);
        in       = v;
        valid_in = 1'b1;
        sb.push_back(ref_model(v, cyc + 1 + N));
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 60) begin
            @(posedge clk);
            t++;
        end
        #2;
        if (sb.size() != 0) begin
            chk("timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic drop_valid();
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    vec_t v;

    initial begin
        rst       = 1'b1;
        valid_in  = 1'b0;
        in        = '0;
        in2       = '0;
        valid_in2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_class", 32'(class_out), 32'd0);
        chk("rst_max", 32'(max_out), 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // basic: ramp with a spike at 7, busy window checked edge by edge
        for (int i = 0; i < N; i++) v[i] = 16'(i * 16'h0100);
        v[7] = 16'h7000;
        start_job(v);
        for (int i = 0; i < N; i++) begin
            @(posedge clk);
            #1;
            chk("busy_on", 32'(busy), 32'd1);
        end
        @(posedge clk);
        #1;
        chk("busy_off", 32'(busy), 32'd0);
        chk("pulse_class7", 32'(class_out), 32'd7);
        @(posedge clk);
        #1;
        chk("pulse_fall", 32'(valid_out), 32'd0);
        wait_idle();
        drop_valid();

        // negatives: -1 beats most-negative
        for (int i = 0; i < N; i++) v[i] = 16'h8000;
        v[3] = 16'hFFFF;
        start_job(v);
        wait_idle();
        chk("neg_class", 32'(class_out), 32'd3);
        chk("neg_max", 32'(max_out), 32'hFFFF);
        drop_valid();

        // all equal: lowest index wins
        for (int i = 0; i < N; i++) v[i] = 16'h1234;
        start_job(v);
        wait_idle();
        chk("tie_class", 32'(class_out), 32'd0);
        drop_valid();

        // held level: one pulse, then a fresh edge gives a second one
        for (int i = 0; i < N; i++) v[i] = 16'(16'hF000 + i * 3);
        v[5] = 16'h0042;
        start_job(v);
        repeat (40) @(negedge clk);
        chk("hold_drained", 32'(sb.size()), 32'd0);
        valid_in = 1'b0;
        start_job(v);
        wait_idle();
        chk("retrig_class", 32'(class_out), 32'd5);
        drop_valid();

        // edge during busy with new data is dropped
        for (int i = 0; i < N; i++) v[i] = 16'(i);
        v[2] = 16'h0500;
        start_job(v);
        drop_valid();
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) in[i] = 16'h0001;
        in[9]    = 16'h7FFF;
        valid_in = 1'b1;
        wait_idle();
        repeat (15) @(negedge clk);
        chk("busy_ign_class", 32'(class_out), 32'd2);
        chk("busy_ign_max", 32'(max_out), 32'h0500);
        valid_in = 1'b0;
        @(negedge clk);

        // reset at edge k+4, valid_in still high on release
        for (int i = 0; i < N; i++) v[i] = 16'(16'h0010 + i);
        start_job(v);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        void'(sb.pop_back());
        @(posedge clk);
        #1;
        chk("mid_rst_class", 32'(class_out), 32'd0);
        chk("mid_rst_max", 32'(max_out), 32'd0);
        chk("mid_rst_valid", 32'(valid_out), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sb.push_back(ref_model(v, cyc + 1 + N));
        wait_idle();
        chk("post_rst_class", 32'(class_out), 32'd9);
        drop_valid();

        // boundary indices
        for (int i = 0; i < N; i++) v[i] = 16'hFF00;
        v[9] = 16'h0000;
        start_job(v);
        wait_idle();
        chk("edge_hi", 32'(class_out), 32'd9);
        drop_valid();
        for (int i = 0; i < N; i++) v[i] = 16'hFF00;
        v[0] = 16'h0000;
        start_job(v);
        wait_idle();
        chk("edge_lo", 32'(class_out), 32'd0);
        drop_valid();

        // random vectors against the model
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) v[i] = 16'($urandom);
            start_job(v);
            wait_idle();
            drop_valid();
        end

        // two-class instance: latency of 2 cycles
        @(negedge clk);
        in2[0]    = 16'hFFFB;
        in2[1]    = 16'h0003;
        valid_in2 = 1'b1;
        @(posedge clk);
        #1;
        chk("n2_busy", 32'(busy2), 32'd1);
        chk("n2_early", 32'(valid2), 32'd0);
        @(posedge clk);
        #1;
        chk("n2_early2", 32'(valid2), 32'd0);
        @(posedge clk);
        #1;
        chk("n2_valid", 32'(valid2), 32'd1);
        chk("n2_class", 32'(class2), 32'd1);
        chk("n2_max", 32'(max2), 32'h0003);
        @(negedge clk);
        valid_in2 = 1'b0;
        repeat (20) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
